// File: rtl/alu_shift_pkg.sv
// Shared definitions for the pipelined shift unit: opcode encodings, the
// opcode enum, the decoded-op struct carried down the pipe, and the decoder.
package alu_shift_pkg;

  localparam logic [2:0] OPC_ROL = 3'b010;
  localparam logic [2:0] OPC_ROR = 3'b011;
  localparam logic [2:0] OPC_SLL = 3'b101;  // legacy SLL encoding kept unchanged
  localparam logic [2:0] OPC_SRL = 3'b110;
  localparam logic [2:0] OPC_SRA = 3'b111;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    OP_ROL = OPC_ROL,
    OP_ROR = OPC_ROR,
    OP_SLL = OPC_SLL,
    OP_SRL = OPC_SRL,
    OP_SRA = OPC_SRA
  } shift_op_e;

  // dir: 0 left / 1 right; arith: sign fill on right shifts; rot: wrap bits
  // around; illegal: opcode is not a shift, result is forced to zero.
  typedef struct packed {
    logic dir;
    logic arith;
    logic rot;
    logic illegal;
  } shift_dec_t;

  function automatic shift_dec_t decode_op(input logic [2:0] opc);
    shift_dec_t d;
    d = '0;
    case (shift_op_e'(opc))
      OP_SLL: d.dir = DIR_LEFT;
      OP_SRL: d.dir = DIR_RIGHT;
      OP_SRA: begin
        d.dir   = DIR_RIGHT;
        d.arith = 1'b1;
      end
      OP_ROL: begin
        d.dir = DIR_LEFT;
        d.rot = 1'b1;
      end
      OP_ROR: begin
        d.dir = DIR_RIGHT;
        d.rot = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// One register slice of the shift pipeline. It applies shifter levels
// [LVL_LO, LVL_HI) to the incoming operand and registers the result together
// with the remaining shift amount, decoded op and tag.
//
// Handshake: a beat moves across a boundary when valid && ready. This slice
// loads a new beat whenever it is empty or its own beat is leaving this cycle
// (i_adv = the next slice, or the output port, is ready). i_adv is computed by
// the parent from the slice valids, so no combinational ready chain exists.
module alu_shift_stage
  import alu_shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 4,
  parameter int SHW    = 5,
  parameter int LVL_LO = 0,
  parameter int LVL_HI = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_adv,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  shift_dec_t       i_dec,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [SHW-1:0]   o_shamt,
  output shift_dec_t       o_dec,
  output logic [TAG_W-1:0] o_tag
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_shamt;
  shift_dec_t       r_dec;
  logic [TAG_W-1:0] r_tag;

  logic             w_load;
  logic [WIDTH-1:0] w_shifted;

  // One level of the logarithmic shifter; s is a power of two below WIDTH.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                   input int s,
                                                   input shift_dec_t d);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] y;
    fill = {WIDTH{d.arith & x[WIDTH-1]}};
    if (d.dir == DIR_LEFT) begin
      y = x << s;
      if (d.rot) y = y | (x >> (WIDTH - s));
    end else begin
      y = x >> s;
      if (d.rot) y = y | (x << (WIDTH - s));
      else       y = y | (fill << (WIDTH - s));
    end
    return y;
  endfunction

  // Apply this slice's share of the shifter levels.
  always_comb begin
    w_shifted = i_data;
    for (int l = LVL_LO; l < LVL_HI; l++) begin
      if (i_shamt[l]) w_shifted = shift_level(w_shifted, 1 << l, i_dec);
    end
  end

  assign w_load = !r_valid || i_adv;

  // Slice register: take a new beat when empty or draining; payload only
  // changes when a valid beat is captured so stalled outputs stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_dec   <= '0;
      r_tag   <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= w_shifted;
        r_shamt <= i_shamt;
        r_dec   <= i_dec;
        r_tag   <= i_tag;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shamt = r_shamt;
  assign o_dec   = r_dec;
  assign o_tag   = r_tag;

endmodule

// File: rtl/alu_shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR unit. The opcode is decoded in front of the
// first slice; saturation and illegal opcodes are resolved there by replacing
// the operand with its final value and zeroing the shift amount. The SHW
// shifter levels are spread over STAGES slices, ceil(SHW/STAGES) each.
module alu_shift_pipe
  import alu_shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int TAG_W     = 4,
  parameter int SAT_SHAMT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int PER = (SHW + STAGES - 1) / STAGES;

  logic [STAGES-1:0] w_vld;
  logic [STAGES:0]   w_rdy;
  logic [WIDTH-1:0]  w_data  [STAGES+1];
  logic [SHW-1:0]    w_shamt [STAGES+1];
  shift_dec_t        w_dec   [STAGES+1];
  logic [TAG_W-1:0]  w_tag   [STAGES+1];

  shift_dec_t        w_in_dec;
  logic              w_sat;
  logic [WIDTH-1:0]  w_in_data;
  logic [SHW-1:0]    w_in_shamt;
  logic              w_unused_tail;

  // Decode the request and fold saturated / illegal ops into a fixed operand.
  always_comb begin
    w_in_dec   = decode_op(opcode);
    w_sat      = (SAT_SHAMT != 0) && !w_in_dec.rot && (|B[WIDTH-1:SHW]);
    w_in_data  = A;
    w_in_shamt = B[SHW-1:0];
    if (w_in_dec.illegal) begin
      w_in_data  = '0;
      w_in_shamt = '0;
    end else if (w_sat) begin
      w_in_data  = {WIDTH{w_in_dec.arith & A[WIDTH-1]}};
      w_in_shamt = '0;
    end
  end

  assign w_data[0]  = w_in_data;
  assign w_shamt[0] = w_in_shamt;
  assign w_dec[0]   = w_in_dec;
  assign w_tag[0]   = in_tag;

  assign w_rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * PER < SHW) ? k * PER : SHW;
    localparam int HI = ((k + 1) * PER < SHW) ? (k + 1) * PER : SHW;

    logic w_vin;
    if (k == 0) begin : g_first
      assign w_vin = in_valid;
    end else begin : g_next
      assign w_vin = w_vld[k-1];
    end

    // Slice k can accept when the output drains or any slice from k on is empty.
    assign w_rdy[k] = out_ready | ~(&w_vld[STAGES-1:k]);

    alu_shift_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .SHW   (SHW),
      .LVL_LO(LO),
      .LVL_HI(HI)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .i_valid(w_vin),
      .i_adv  (w_rdy[k+1]),
      .i_data (w_data[k]),
      .i_shamt(w_shamt[k]),
      .i_dec  (w_dec[k]),
      .i_tag  (w_tag[k]),
      .o_valid(w_vld[k]),
      .o_data (w_data[k+1]),
      .o_shamt(w_shamt[k+1]),
      .o_dec  (w_dec[k+1]),
      .o_tag  (w_tag[k+1])
    );
  end

  assign in_ready    = w_rdy[0];
  assign out_valid   = w_vld[STAGES-1];
  assign result      = w_data[STAGES];
  assign out_tag     = w_tag[STAGES];
  assign out_illegal = w_dec[STAGES].illegal;

  // Shift amount and direction bits are fully consumed by the last slice.
  assign w_unused_tail = ^{w_shamt[STAGES], w_dec[STAGES].dir,
                           w_dec[STAGES].arith, w_dec[STAGES].rot};

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Bench for alu_shift_pipe: directed vectors, backpressure, throughput and
// mid-flight reset, checked through an expected-result queue and monitor.
module tb_alu_shift_pipe;
  import alu_shift_pkg::*;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;
  localparam int SAT    = 1;
  localparam int SB_W   = TAG_W + 1 + WIDTH;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  alu_shift_pipe #(
    .WIDTH    (WIDTH),
    .STAGES   (STAGES),
    .TAG_W    (TAG_W),
    .SAT_SHAMT(SAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .opcode     (opcode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_illegal(out_illegal),
    .out_tag    (out_tag)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int rdy_mode = 0;   // 0: always ready, 1: ready 1-of-3 cycles, 2: never ready
  bit lat_chk = 1'b0;
  logic [SB_W-1:0] exp_q[$];
  int              iss_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bit-by-bit reference used for the generated streams.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    int amt;
    bit big;
    r   = '0;
    amt = int'(b % 32);
    big = (SAT != 0) && (b >= 32);
    for (int i = 0; i < 32; i++) begin
      case (op)
        OPC_SLL: r[i] = big ? 1'b0 : ((i >= amt) ? a[i-amt] : 1'b0);
        OPC_SRL: r[i] = big ? 1'b0 : ((i + amt < 32) ? a[i+amt] : 1'b0);
        OPC_SRA: r[i] = big ? a[31] : ((i + amt < 32) ? a[i+amt] : a[31]);
        OPC_ROL: r[i] = a[(i - amt + 32) % 32];
        OPC_ROR: r[i] = a[(i + amt) % 32];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] e, input logic ill,
                      output int stalls);
    bit done;
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    in_tag   = tag;
    stalls   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({tag, ill, e});
        iss_q.push_back(cyc);
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 100) begin
          chk("send_timeout", 64'(stalls), 64'd0);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  logic            held_v;
  logic [SB_W-1:0] held;

  initial begin
    logic [SB_W-1:0] e;
    int is;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        if (held_v)
          chk("stall_hold", {out_valid, out_tag, out_illegal, result}, {1'b1, held});
        if (exp_q.size() == 0)
          chk("spurious_out", 64'(out_valid), 64'd0);
        if (out_valid && out_ready) begin
          held_v = 1'b0;
          if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            is = iss_q.pop_front();
            chk("result", 64'(result), 64'(e[WIDTH-1:0]));
            chk("illegal", 64'(out_illegal), 64'(e[WIDTH]));
            chk("tag", 64'(out_tag), 64'(e[SB_W-1 -: TAG_W]));
            if (lat_chk) chk("latency", 64'(cyc - is), 64'(STAGES));
            out_cnt++;
          end
        end else if (out_valid) begin
          held_v = 1'b1;
          held   = {out_tag, out_illegal, result};
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e0;   // expected with plain shift amount
    logic [31:0] e1;   // expected with saturating shift amount
    logic        ill;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  // ---------------- main sequence ----------------
  initial begin
    int st;
    int tot;
    int base;
    int c0;
    logic [2:0] ops[5];
    logic [31:0] a;
    logic [31:0] b;

    ops[0] = OPC_SLL; ops[1] = OPC_SRL; ops[2] = OPC_SRA; ops[3] = OPC_ROL; ops[4] = OPC_ROR;

    vecs[0]  = '{OPC_SLL, 32'h0000_0001, 32'd31,  32'h8000_0000, 32'h8000_0000, 1'b0};
    vecs[1]  = '{OPC_SLL, 32'h0000_0001, 32'd32,  32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[2]  = '{OPC_SRA, 32'h8000_0000, 32'd4,   32'hF800_0000, 32'hF800_0000, 1'b0};
    vecs[3]  = '{OPC_SRL, 32'h8000_0000, 32'd4,   32'h0800_0000, 32'h0800_0000, 1'b0};
    vecs[4]  = '{OPC_SRA, 32'h8000_0000, 32'd40,  32'hFF80_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{OPC_ROL, 32'h8000_0001, 32'd1,   32'h0000_0003, 32'h0000_0003, 1'b0};
    vecs[6]  = '{OPC_ROR, 32'h8000_0001, 32'd33,  32'hC000_0000, 32'hC000_0000, 1'b0};
    vecs[7]  = '{3'b000,  32'h0000_1234, 32'd1,   32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{3'b001,  32'hFFFF_FFFF, 32'd3,   32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{3'b100,  32'h0000_FFFF, 32'd0,   32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[10] = '{OPC_SLL, 32'hDEAD_BEEF, 32'd0,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{OPC_SRL, 32'hDEAD_BEEF, 32'd8,   32'h00DE_ADBE, 32'h00DE_ADBE, 1'b0};
    vecs[12] = '{OPC_SRA, 32'h7FFF_FFFF, 32'd31,  32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[13] = '{OPC_ROL, 32'h1234_5678, 32'd8,   32'h3456_7812, 32'h3456_7812, 1'b0};
    vecs[14] = '{OPC_ROR, 32'h1234_5678, 32'd4,   32'h8123_4567, 32'h8123_4567, 1'b0};
    vecs[15] = '{OPC_SRL, 32'hFFFF_FFFF, 32'd40,  32'h00FF_FFFF, 32'h0000_0000, 1'b0};
    vecs[16] = '{OPC_SRA, 32'h1234_5678, 32'd100, 32'h0123_4567, 32'h0000_0000, 1'b0};
    vecs[17] = '{OPC_ROL, 32'h1234_5678, 32'd36,  32'h2345_6781, 32'h2345_6781, 1'b0};
    vecs[18] = '{OPC_SLL, 32'h0000_000F, 32'd29,  32'hE000_0000, 32'hE000_0000, 1'b0};
    vecs[19] = '{OPC_SRA, 32'hF000_0000, 32'd31,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[20] = '{OPC_SLL, 32'hABCD_1234, 32'd16,  32'h1234_0000, 32'h1234_0000, 1'b0};
    vecs[21] = '{OPC_ROR, 32'hDEAD_BEEF, 32'd32,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;

    // Directed vectors, back to back, latency checked
    lat_chk = 1'b1;
    tot = 0;
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i), (SAT != 0) ? vecs[i].e1 : vecs[i].e0,
           vecs[i].ill, st);
      tot += st;
    end
    idle();
    drain();
    chk("dir_stalls", 64'(tot), 64'd0);
    lat_chk = 1'b0;

    // Backpressure: 10 ops, downstream ready one cycle in three
    rdy_mode = 1;
    base = out_cnt;
    for (int i = 0; i < 10; i++) begin
      a = 32'hA5C3_0F1E ^ (32'h0101_0101 * 32'(i));
      b = 32'(i * 7);
      send(ops[i % 5], a, b, TAG_W'(i), ref_shift(ops[i % 5], a, b), 1'b0, st);
    end
    idle();
    drain();
    chk("bp_count", 64'(out_cnt - base), 64'd10);

    // Throughput: 100 ops with downstream always ready
    rdy_mode = 0;
    @(posedge clk);
    #1;
    base = out_cnt;
    tot  = 0;
    c0   = cyc;
    for (int i = 0; i < 100; i++) begin
      a = 32'h9E37_79B9 * 32'(i + 1);
      b = 32'((i * 13) % 64);
      send(ops[i % 5], a, b, TAG_W'(i), ref_shift(ops[i % 5], a, b), 1'b0, st);
      tot += st;
    end
    chk("tput_cycles", 64'(cyc - c0), 64'd100);
    idle();
    drain();
    chk("tput_stalls", 64'(tot), 64'd0);
    chk("tput_count", 64'(out_cnt - base), 64'd100);

    // Reset with the pipe full and stalled
    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < STAGES; i++) begin
      send(OPC_SLL, 32'h1, 32'(i + 1), TAG_W'(i + 5), 32'h1 << (i + 1), 1'b0, st);
    end
    idle();
    @(negedge clk);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rdy_mode = 0;
    base     = out_cnt;
    @(negedge clk);
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_no_output", 64'(out_cnt - base), 64'd0);

    // Pipe still works after reset
    lat_chk = 1'b1;
    send(OPC_ROR, 32'h8000_0001, 32'd1, 4'hA, 32'hC000_0000, 1'b0, st);
    idle();
    drain();
    chk("postrst_count", 64'(out_cnt - base), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
